// File: rtl/dds_spi_scheduler_if.sv
// Bundle of requester handshake and DDS serial-port pins for dds_spi_scheduler.
// The slave modport is the scheduler. The master modport is the requester/board side.
interface dds_spi_scheduler_if;
  logic [1:0]  req;
  logic [7:0]  addr0, addr1;
  logic [63:0] data0, data1;
  logic [2:0]  nb0, nb1;
  logic        upd0, upd1;
  logic [1:0]  ack;
  logic        busy;
  logic        SDIO;
  logic        SCLK;
  logic        CSB;
  logic        IO_UPDATE;
  logic        IO_RESET;

  modport master (
    output req, addr0, addr1, data0, data1, nb0, nb1, upd0, upd1,
    input  ack, busy, SDIO, SCLK, CSB, IO_UPDATE, IO_RESET
  );

  modport slave (
    input  req, addr0, addr1, data0, data1, nb0, nb1, upd0, upd1,
    output ack, busy, SDIO, SCLK, CSB, IO_UPDATE, IO_RESET
  );
endinterface

// File: rtl/dds_spi_scheduler.sv
// Round-robin scheduler that shares one DDS serial port between two register writers.
// Optional macro DDS_IORESET_EN pulses IO_RESET before every frame.
module dds_spi_scheduler #(
  parameter int unsigned CSB_SETUP  = 2,
  parameter int unsigned UPD_CYCLES = 5,
  parameter int unsigned RST_CYCLES = 5
) (
  input logic               TenMHzExt,
  input logic               reset,
  dds_spi_scheduler_if.slave bus
);

  if (CSB_SETUP < 1 || CSB_SETUP > 15 || UPD_CYCLES < 1 || UPD_CYCLES > 15 ||
      RST_CYCLES < 1 || RST_CYCLES > 15) begin : g_param_check
    $error("dds_spi_scheduler: timing parameters must lie in 1..15");
  end

  localparam logic [3:0] SETUP_LOAD = 4'(CSB_SETUP - 1);
  localparam logic [3:0] UPD_LOAD   = 4'(UPD_CYCLES - 1);
`ifdef DDS_IORESET_EN
  localparam logic [3:0] RST_LOAD   = 4'(RST_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef DDS_IORESET_EN
    S_IORST,
`endif
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_UPDATE,
    S_DONE
  } state_e;

  state_e      state_q;
  logic        rr_q;
  logic        gnt_q;
  logic        upd_q;
  logic [71:0] sh_q;
  logic [6:0]  bits_q;
  logic [3:0]  cnt_q;
  logic        sdio_q, sclk_q, csb_q, io_update_q, io_reset_q, busy_q;
  logic [1:0]  ack_q;

  logic        gnt_d;
  logic        upd_d;
  logic [7:0]  addr_sel;
  logic [63:0] data_sel;
  logic [2:0]  nb_sel;
  logic [71:0] sh_d;
  logic [6:0]  bits_d;

  // Grant decode and payload capture. The data is left-aligned so the first
  // data bit always sits just below the instruction byte.
  // NOTE: every always_comb output gets a value on every path; a missed
  // branch would silently infer a latch.
  always_comb begin
    gnt_d    = (bus.req == 2'b11) ? rr_q : bus.req[1];
    addr_sel = gnt_d ? bus.addr1 : bus.addr0;
    data_sel = gnt_d ? bus.data1 : bus.data0;
    nb_sel   = gnt_d ? bus.nb1   : bus.nb0;
    upd_d    = gnt_d ? bus.upd1  : bus.upd0;
    sh_d     = {addr_sel, data_sel << {3'd7 - nb_sel, 3'b000}};
    bits_d   = 7'd16 + {1'b0, nb_sel, 3'b000};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge TenMHzExt) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      upd_q       <= 1'b0;
      sh_q        <= '0;
      bits_q      <= '0;
      cnt_q       <= '0;
      sdio_q      <= 1'b0;
      sclk_q      <= 1'b0;
      csb_q       <= 1'b1;
      io_update_q <= 1'b0;
      io_reset_q  <= 1'b0;
      ack_q       <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            gnt_q  <= gnt_d;
            rr_q   <= ~gnt_d;
            sh_q   <= sh_d;
            bits_q <= bits_d;
            upd_q  <= upd_d;
            busy_q <= 1'b1;
`ifdef DDS_IORESET_EN
            state_q    <= S_IORST;
            io_reset_q <= 1'b1;
            cnt_q      <= RST_LOAD;
`else
            state_q <= S_SETUP;
            csb_q   <= 1'b0;
            sdio_q  <= sh_d[71];
            cnt_q   <= SETUP_LOAD;
`endif
          end
        end
`ifdef DDS_IORESET_EN
        S_IORST: begin
          if (cnt_q == 4'd0) begin
            state_q    <= S_SETUP;
            io_reset_q <= 1'b0;
            csb_q      <= 1'b0;
            sdio_q     <= sh_q[71];
            cnt_q      <= SETUP_LOAD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        S_SETUP: begin
          if (cnt_q == 4'd0) state_q <= S_SHIFT;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        // sclk_q doubles as the bit phase: low = phase A, high = phase B.
        S_SHIFT: begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else if (bits_q == 7'd1) begin
            state_q <= S_HOLD;
            sclk_q  <= 1'b0;
            csb_q   <= 1'b1;
            sdio_q  <= 1'b0;
          end else begin
            sclk_q <= 1'b0;
            sh_q   <= sh_q << 1;
            sdio_q <= sh_q[70];
            bits_q <= bits_q - 7'd1;
          end
        end
        S_HOLD: begin
          if (upd_q) begin
            state_q     <= S_UPDATE;
            io_update_q <= 1'b1;
            cnt_q       <= UPD_LOAD;
          end else begin
            state_q <= S_DONE;
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
          end
        end
        S_UPDATE: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_DONE;
            io_update_q <= 1'b0;
            ack_q       <= gnt_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ack_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.SDIO      = sdio_q;
  assign bus.SCLK      = sclk_q;
  assign bus.CSB       = csb_q;
  assign bus.IO_UPDATE = io_update_q;
  assign bus.IO_RESET  = io_reset_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;

endmodule
